// File: rtl/alu_arb_pkg.sv
//==============================================================================
// Module : alu_arb_pkg
// Brief  : Shared types and constants for the two-port ALU arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int unsigned PORT_EXE = 0;
   localparam int unsigned PORT_AGU = 1;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu.sv
//==============================================================================
// Module : alu
// Brief  : Core 32-bit combinational ALU (funct3 / funct7[5] decode).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu
   import alu_arb_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  funct3,
   input  logic        funct7_5b,
   output logic [31:0] out
);

   logic [4:0] w_shamt;
   logic       w_lt_s;
   logic       w_lt_u;

   assign w_shamt = b[4:0];
   assign w_lt_s  = $signed(a) < $signed(b);
   assign w_lt_u  = a < b;

   // funct7_5b turns a<b into a>=b for both compare flavours
   always_comb begin
      out = 32'd0;
      case (funct3)
         F3_ADD:  out = funct7_5b ? (a - b) : (a + b);
         F3_SLL:  out = a << w_shamt;
         F3_SLT:  out = {31'd0, w_lt_s ^ funct7_5b};
         F3_SLTU: out = {31'd0, w_lt_u ^ funct7_5b};
         F3_XOR:  out = a ^ b;
         F3_SR:   out = funct7_5b ? $unsigned($signed(a) >>> w_shamt) : (a >> w_shamt);
         F3_OR:   out = a | b;
         F3_AND:  out = a & b;
         default: out = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_arb_grant.sv
//==============================================================================
// Module : alu_arb_grant
// Brief  : One-hot grant between the two ALU requesters, valid only in IDLE.
//          ALU_ARB_RR_EN selects round-robin, otherwise port 0 has priority.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_arb_grant
   import alu_arb_pkg::*;
(
   input  logic [1:0] i_valid,
   input  logic       i_idle,
`ifdef ALU_ARB_RR_EN
   input  logic       i_last_grant,
`endif
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      if (i_idle) begin
`ifdef ALU_ARB_RR_EN
         // on contention the port not served last wins
         if (i_valid[PORT_EXE] && i_valid[PORT_AGU]) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
         end else begin
            o_grant = i_valid;
         end
`else
         o_grant[PORT_EXE] = i_valid[PORT_EXE];
         o_grant[PORT_AGU] = i_valid[PORT_AGU] & ~i_valid[PORT_EXE];
`endif
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
//==============================================================================
// Module : alu_arbiter
// Brief  : Shares one ALU between execute (port 0) and AGU (port 1) with a
//          IDLE->EXEC->RESP sequencer. ALU_ARB_RR_EN enables round-robin.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [2:0]       req0_funct3,
   input  logic             req0_funct7_5b,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [2:0]       req1_funct3,
   input  logic             req1_funct7_5b,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [31:0]      rsp0_data,
   output logic [TAG_W-1:0] rsp0_tag,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp1_data,
   output logic [TAG_W-1:0] rsp1_tag
);

   arb_state_t       r_state;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [2:0]       r_funct3;
   logic             r_funct7_5b;
   logic [TAG_W-1:0] r_tag;
   logic             r_gidx;
   logic [31:0]      r_result;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;

   logic [1:0]       w_grant;
   logic             w_accept;
   logic             w_sel1;
   logic             w_rsp_done;
   logic [31:0]      w_alu_out;

`ifdef ALU_ARB_RR_EN
   logic             r_last_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         r_last_grant <= w_grant[PORT_AGU];
      end
   end
`endif

   alu_arb_grant u_grant (
      .i_valid      ({req1_valid, req0_valid}),
      .i_idle       (r_state == IDLE),
`ifdef ALU_ARB_RR_EN
      .i_last_grant (r_last_grant),
`endif
      .o_grant      (w_grant)
   );

   alu u_alu (
      .a         (r_a),
      .b         (r_b),
      .funct3    (r_funct3),
      .funct7_5b (r_funct7_5b),
      .out       (w_alu_out)
   );

   assign req0_ready = w_grant[PORT_EXE];
   assign req1_ready = w_grant[PORT_AGU];
   assign w_accept   = |w_grant;
   assign w_sel1     = w_grant[PORT_AGU];
   assign w_rsp_done = (r_rsp0_valid & rsp0_ready) | (r_rsp1_valid & rsp1_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_a          <= 32'd0;
         r_b          <= 32'd0;
         r_funct3     <= 3'd0;
         r_funct7_5b  <= 1'b0;
         r_tag        <= '0;
         r_gidx       <= 1'b0;
         r_result     <= 32'd0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a         <= w_sel1 ? req1_a         : req0_a;
                  r_b         <= w_sel1 ? req1_b         : req0_b;
                  r_funct3    <= w_sel1 ? req1_funct3    : req0_funct3;
                  r_funct7_5b <= w_sel1 ? req1_funct7_5b : req0_funct7_5b;
                  r_tag       <= w_sel1 ? req1_tag       : req0_tag;
                  r_gidx      <= w_sel1;
                  r_state     <= EXEC;
               end
            end
            EXEC: begin
               r_result     <= w_alu_out;
               r_rsp0_valid <= ~r_gidx;
               r_rsp1_valid <= r_gidx;
               r_state      <= RESP;
            end
            RESP: begin
               if (w_rsp_done) begin
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // tag is captured at accept, so it is already stable when RESP begins
   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp0_data  = r_result;
   assign rsp1_data  = r_result;
   assign rsp0_tag   = r_tag;
   assign rsp1_tag   = r_tag;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//==============================================================================
// Module : tb_alu_arbiter
// Brief  : Directed self-checking bench for alu_arbiter (honours ALU_ARB_RR_EN).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a [2];
   logic [31:0] req_b [2];
   logic [2:0]  req_f3 [2];
   logic [1:0]  req_f7;
   logic [3:0]  req_tag [2];
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data [2];
   logic [3:0]  rsp_tag [2];

   int n_assert;
   int n_fail;

   alu_arbiter #(.TAG_W(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req0_valid     (req_valid[0]),
      .req0_ready     (req_ready[0]),
      .req0_a         (req_a[0]),
      .req0_b         (req_b[0]),
      .req0_funct3    (req_f3[0]),
      .req0_funct7_5b (req_f7[0]),
      .req0_tag       (req_tag[0]),
      .req1_valid     (req_valid[1]),
      .req1_ready     (req_ready[1]),
      .req1_a         (req_a[1]),
      .req1_b         (req_b[1]),
      .req1_funct3    (req_f3[1]),
      .req1_funct7_5b (req_f7[1]),
      .req1_tag       (req_tag[1]),
      .rsp0_valid     (rsp_valid[0]),
      .rsp0_ready     (rsp_ready[0]),
      .rsp0_data      (rsp_data[0]),
      .rsp0_tag       (rsp_tag[0]),
      .rsp1_valid     (rsp_valid[1]),
      .rsp1_ready     (rsp_ready[1]),
      .rsp1_data      (rsp_data[1]),
      .rsp1_tag       (rsp_tag[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic f7, input logic [3:0] tg);
      req_a[p]   = a;
      req_b[p]   = b;
      req_f3[p]  = f3;
      req_f7[p]  = f7;
      req_tag[p] = tg;
   endtask

   // Called at a negedge in IDLE with both rsp_ready high; returns at a negedge in IDLE.
   task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic f7, input logic [3:0] tg,
                         input logic [31:0] exp);
      set_req(p, a, b, f3, f7, tg);
      req_valid[p] = 1'b1;
      #1;
      chk("idle_ready", {30'd0, req_ready}, (p == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      req_valid[p] = 1'b0;
      chk("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("resp_valid", {30'd0, rsp_valid}, (p == 0) ? 32'd1 : 32'd2);
      chk("resp_data", rsp_data[p], exp);
      chk("resp_tag", {28'd0, rsp_tag[p]}, {28'd0, tg});
      @(negedge clk);
      chk("post_rsp_valid", {30'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      int exp_p;
      n_assert  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      req_f7    = 2'b00;
      for (int i = 0; i < 2; i++) set_req(i, 32'd0, 32'd0, 3'd0, 1'b0, 4'd0);

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_rsp0_data", rsp_data[0], 32'd0);
      chk("rst_rsp1_tag", {28'd0, rsp_tag[1]}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // single ops on each port
      run_op(0, 32'd5, 32'd7, 3'b000, 1'b0, 4'd3, 32'd12);
      run_op(1, 32'd0, 32'd1, 3'b000, 1'b1, 4'd6, 32'hFFFF_FFFF);
      run_op(1, 32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0, 4'd7, 32'd1);
      run_op(1, 32'h8000_0000, 32'd4, 3'b101, 1'b1, 4'd8, 32'hF800_0000);
      run_op(0, 32'hFFFF_FFFF, 32'd1, 3'b011, 1'b1, 4'd1, 32'd1);
      run_op(0, 32'd1, 32'd31, 3'b001, 1'b0, 4'd2, 32'h8000_0000);
      run_op(0, 32'h8000_0000, 32'd4, 3'b101, 1'b0, 4'd4, 32'h0800_0000);
      run_op(1, 32'hF0F0_1234, 32'h0FF0_00FF, 3'b100, 1'b0, 4'd9, 32'hFF00_12CB);
      run_op(0, 32'hF0F0_1234, 32'h0FF0_00FF, 3'b110, 1'b0, 4'd10, 32'hFFF0_12FF);
      run_op(1, 32'hF0F0_1234, 32'h0FF0_00FF, 3'b111, 1'b0, 4'd11, 32'h00F0_0034);
      run_op(1, 32'h7FFF_FFFF, 32'h8000_0000, 3'b010, 1'b1, 4'd12, 32'd1);

      // contention from a fresh reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      set_req(0, 32'd10, 32'd3, 3'b000, 1'b0, 4'hA);
      set_req(1, 32'd10, 32'd3, 3'b000, 1'b1, 4'hB);
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
         exp_p = i % 2;
`else
         exp_p = 0;
`endif
         #1;
         chk("cont_ready", {30'd0, req_ready}, (exp_p == 0) ? 32'd1 : 32'd2);
         @(negedge clk);
         chk("cont_exec_ready", {30'd0, req_ready}, 32'd0);
         @(negedge clk);
         chk("cont_rsp_valid", {30'd0, rsp_valid}, (exp_p == 0) ? 32'd1 : 32'd2);
         chk("cont_rsp_data", rsp_data[exp_p], (exp_p == 0) ? 32'd13 : 32'd7);
         chk("cont_rsp_tag", {28'd0, rsp_tag[exp_p]}, (exp_p == 0) ? 32'hA : 32'hB);
         if (i == 3) req_valid = 2'b00;
         @(negedge clk);
      end

      // response backpressure on port 0 with port 1 waiting
      rsp_ready[0] = 1'b0;
      set_req(0, 32'd100, 32'd23, 3'b000, 1'b1, 4'd9);
      req_valid[0] = 1'b1;
      @(negedge clk);
      req_valid[0] = 1'b0;
      set_req(1, 32'd1, 32'd2, 3'b000, 1'b0, 4'd5);
      req_valid[1] = 1'b1;
      #1;
      chk("bp_exec_ready1", {31'd0, req_ready[1]}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp0_valid", {31'd0, rsp_valid[0]}, 32'd1);
         chk("bp_rsp0_data", rsp_data[0], 32'd77);
         chk("bp_rsp0_tag", {28'd0, rsp_tag[0]}, 32'd9);
         chk("bp_ready1", {31'd0, req_ready[1]}, 32'd0);
      end
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_released_valid", {30'd0, rsp_valid}, 32'd0);
      chk("bp_idle_ready1", {31'd0, req_ready[1]}, 32'd1);
      @(negedge clk);
      req_valid[1] = 1'b0;
      chk("bp_next_exec", {30'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("bp_next_valid", {30'd0, rsp_valid}, 32'd2);
      chk("bp_next_data", rsp_data[1], 32'd3);
      chk("bp_next_tag", {28'd0, rsp_tag[1]}, 32'd5);
      @(negedge clk);

      // reset mid-EXEC drops the op
      set_req(1, 32'd40, 32'd2, 3'b000, 1'b0, 4'd14);
      req_valid[1] = 1'b1;
      @(negedge clk);
      req_valid[1] = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_exec_valid", {30'd0, rsp_valid}, 32'd0);
      chk("rst_exec_data", rsp_data[1], 32'd0);
      chk("rst_exec_tag", {28'd0, rsp_tag[1]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_rsp", {30'd0, rsp_valid}, 32'd0);
      end
      run_op(0, 32'd6, 32'd3, 3'b111, 1'b0, 4'd15, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer that shares the core's single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch unit. It accepts one operation at a time over a valid/ready handshake and registers the operands. It evaluates them on the ALU for one cycle, then returns the registered result with the requester's tag over a per-port valid/ready response channel.

## Interface
- TAG_W, default 4: width of the request/response tag.
- clk  in  1: clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- reqN_valid  in  1 (N=0,1): request N present.
- reqN_ready  out  1: request N accepted this cycle.
- reqN_a, reqN_b  in  32: operands.
- reqN_funct3  in  3: ALU operation select.
- reqN_funct7_5b  in  1: ALU variant bit (SUB/SRA/inverted compare).
- reqN_tag  in  TAG_W: opaque tag, returned unchanged.
- rspN_valid  out  1: response N present.
- rspN_ready  in  1: response N consumed.
- rspN_data  out  32: ALU result.
- rspN_tag  out  TAG_W: tag of the accepted request.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate among reqN_valid and raise reqN_ready combinationally for the granted port only.
  - On valid&ready: latch a, b, funct3, funct7_5b, tag and grant index, then go to EXEC.
  - With no valid requester, stay in IDLE.
- EXEC:
  - Drive the ALU from the latched operands.
  - Capture its output into the result register and go to RESP.
  - No ready is asserted in this state.
- RESP:
  - Assert rspG_valid for the granted port G, holding rspG_data and rspG_tag stable.
  - On rspG_ready: go to IDLE.
  - The other port's rsp_valid stays 0.
- ALU semantics (funct3 / funct7_5b), 32-bit wrap-around arithmetic:
  - 000: ADD / SUB.
  - 001: SLL by b[4:0].
  - 010: signed a<b / a>=b, result 0 or 1.
  - 011: unsigned compare, same encoding as 010.
  - 100: XOR.
  - 101: SRL / SRA by b[4:0].
  - 110: OR.
  - 111: AND.
- Simultaneous reqN_valid: resolved by the grant policy (see Configuration).
  - The loser's ready stays 0 and its inputs must remain stable until accepted.
- A request arriving while the block is in EXEC/RESP waits. The next IDLE cycle accepts it with no bubble beyond that IDLE cycle.
- Reset (at any time, including mid-EXEC/RESP):
  - State goes to IDLE; the in-flight op is dropped and no response is issued.
  - All outputs go to 0: reqN_ready=0 (except the combinational grant in IDLE), rspN_valid=0, rspN_data=0, rspN_tag=0.

## Timing
- Accept at edge T (valid&ready sampled high): EXEC during cycle T+1, rspG_valid high from T+2.
- Latency 2 cycles from accept to response valid.
- Minimum op spacing 3 cycles per operation (IDLE→EXEC→RESP→IDLE) with rsp_ready held high.
- reqN_ready is combinational from reqN_valid and state; rspN_* are registered.
- rspG_valid is held until rspG_ready; backpressure adds cycles in RESP indefinitely.

## Configuration
- ALU_ARB_RR_EN defined: round-robin grant.
  - A last_grant register, reset to 1, updates on every accept.
  - On contention the port not served last wins, so port 0 wins the first contention after reset.
- Undefined: fixed priority. Port 0 always wins contention and port 1 can starve; there is no last_grant register.

## Structure
- Package alu_arb_pkg:
  - State enum (IDLE, EXEC, RESP).
  - Port index constants PORT_EXE=0, PORT_AGU=1.
  - Funct3 encoding constants for the eight operations.
- Sub-module alu_arb_grant: takes both valids, state==IDLE and (with the macro) last_grant; produces one-hot grant.
- The core's existing ALU module (ports a, b, funct3, funct7_5b, out) is instantiated once and driven only from the latched operand registers.

## Test plan
- Port 0, a=5, b=7, funct3=000, f7=0, tag=3, rsp0_ready=1 -> rsp0_valid at T+2, data=12, tag=3; rsp1_valid stays 0.
- Port 1, a=0, b=1, funct3=000, f7=1 -> data=0xFFFFFFFF; with funct3=010, a=0xFFFFFFFF, b=1, f7=0 -> data=1; funct3=101, a=0x80000000, b=4, f7=1 -> data=0xF8000000.
- Both ports valid continuously:
  - With ALU_ARB_RR_EN, grants alternate 0,1,0,1 across four ops.
  - Without it, port 0 is granted four times and req1_ready never rises.
- rsp0_ready low for 5 cycles after rsp0_valid -> valid, data and tag held stable; no new accept; accept resumes the cycle after the handshake plus one IDLE cycle.
- rst_n pulsed low during EXEC -> all rsp*_valid=0 and no response for the dropped op; a fresh request after release completes normally with a correct result.
